// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl
//
// Drives one scan chain of sdff-style cells: serially loads a pattern
// (MSB first), issues one functional capture cycle, unloads the captured
// contents from the chain tail and compares them with an expected vector.
//
// Ports
//   CLK       clock shared with the scan cells, rising-edge
//   RN        synchronous active-low reset
//   START     run request, accepted only in IDLE
//   PATTERN   stimulus, bit k lands in cell k (cell 0 = nearest SI)
//   EXPECT    expected captured value, bit k = cell k
//   SE        scan enable to every cell (registered)
//   SI        serial data into cell 0 (registered)
//   SO        Q of the last cell in the chain
//   BUSY      high during SHIFT, CAPTURE and UNLOAD
//   DONE      one-cycle pulse; RESP and FAIL are valid with it
//   RESP      captured chain contents, bit k = cell k
//   FAIL      RESP != EXPECT, updated together with DONE
//   dbg_state current FSM state, for observation only
//
// Handshake: START is a level sampled at each rising edge; it is taken only
// when the FSM is in IDLE and is otherwise dropped (no queuing). DONE is a
// single-cycle qualifier for RESP/FAIL with no backpressure.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(
  parameter int  CHAIN_LEN = 16,
  localparam int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic [CHAIN_LEN-1:0] EXPECT,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 FAIL,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  // Pattern shadow is consumed MSB first, so it is kept as a left shifter.
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] exp_sh;

  logic                 cnt_last;
  logic [CNT_W-1:0]     resp_idx;
  logic [CHAIN_LEN-1:0] resp_upd;

  assign cnt_last  = (cnt == CNT_W'(CHAIN_LEN - 1));
  // Unload cycle j sees cell CHAIN_LEN-1-j on SO.
  assign resp_idx  = CNT_W'(CHAIN_LEN - 1) - cnt;
  assign dbg_state = state;

  // RESP with the current SO sample merged in; FAIL is computed from this
  // so it reflects the final bit on the last unload edge.
  always_comb begin
    resp_upd = RESP;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      if (resp_idx == CNT_W'(k)) resp_upd[k] = SO;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pat_sh <= '0;
      exp_sh <= '0;
      SE     <= 1'b0;
      SI     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESP   <= '0;
      FAIL   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_SHIFT;
            cnt    <= '0;
            SE     <= 1'b1;
            SI     <= PATTERN[CHAIN_LEN-1];
            pat_sh <= {PATTERN[CHAIN_LEN-2:0], 1'b0};
            exp_sh <= EXPECT;
            BUSY   <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_last) begin
            state <= S_CAPTURE;
            cnt   <= '0;
            SE    <= 1'b0;
            SI    <= 1'b0;
          end else begin
            cnt    <= cnt + 1'b1;
            SI     <= pat_sh[CHAIN_LEN-1];
            pat_sh <= {pat_sh[CHAIN_LEN-2:0], 1'b0};
          end
        end
        S_CAPTURE: begin
          state <= S_UNLOAD;
          cnt   <= '0;
          SE    <= 1'b1;
          SI    <= 1'b0;
        end
        S_UNLOAD: begin
          RESP <= resp_upd;
          if (cnt_last) begin
            state <= S_FIN;
            cnt   <= '0;
            SE    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            FAIL  <= |(resp_upd ^ exp_sh);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          SE    <= 1'b0;
          SI    <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl with a 16-cell chain
// of scan-mux flops (Q <= SE ? SI : D). The functional D is either hold
// (D=Q) or invert (D=~Q), chosen per vector.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl;

  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expect_v = '0;
  logic         se, si, so, busy, done, fail;
  logic [N-1:0] resp;
  logic [2:0]   dbg_state;

  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CLK(clk), .RN(rn), .START(start), .PATTERN(pattern), .EXPECT(expect_v),
    .SE(se), .SI(si), .SO(so), .BUSY(busy), .DONE(done), .RESP(resp),
    .FAIL(fail), .dbg_state(dbg_state)
  );

  // ---------------- scan chain model ----------------
  logic [N-1:0] chain = '0;   // bit k = cell k
  logic         d_mode = 1'b0; // 0: hold, 1: invert
  assign so = chain[N-1];
  always @(posedge clk) begin
    if (se) chain <= {chain[N-2:0], si};
    else    chain <= d_mode ? ~chain : chain;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rise_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // One full run; checks SE/SI/BUSY/DONE every cycle and the result at DONE.
  task automatic run_one(input logic mode, input logic [N-1:0] pat, input logic [N-1:0] expv,
                         input logic [N-1:0] exp_resp, input logic exp_fail, input logic clobber);
    logic seen;
    logic exp_si;
    seen     = 1'b0;
    d_mode   = mode;
    pattern  = pat;
    expect_v = expv;
    start    = 1'b1;
    tick();                       // edge 0, now in cycle 1
    start = 1'b0;
    if (clobber) begin
      pattern  = '0;
      expect_v = '0;
    end
    for (int c = 1; c <= 40; c++) begin
      exp_si = (c <= N) ? pat[N-c] : 1'b0;
      check($sformatf("cyc%0d se/si/busy/done", c), {28'd0, se, si, busy, done},
            {28'd0, ((c >= 1 && c <= 16) || (c >= 18 && c <= 33)), exp_si, (c <= 33), (c == 34)});
      if (done) begin
        seen = 1'b1;
        check("done_cycle", c, 34);
        check("resp", resp, exp_resp);
        check("fail", fail, exp_fail);
        break;
      end
      tick();
    end
    if (!seen) check("done_timeout", 0, 1);
    tick();                       // FIN -> IDLE
  endtask

  typedef struct {
    logic         mode;
    logic [N-1:0] pat;
    logic [N-1:0] expv;
    logic [N-1:0] resp;
    logic         fail;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{1'b1, 16'h00FF, 16'hFF00, 16'hFF00, 1'b0};
    vecs[2] = '{1'b1, 16'h00FF, 16'hFF01, 16'hFF00, 1'b1};
    vecs[3] = '{1'b0, 16'h0001, 16'h0001, 16'h0001, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};

    // reset
    rn = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {26'd0, se, si, busy, done, fail, 1'b0}, 32'd0);
    check("rst_resp", resp, 0);
    check("rst_state", dbg_state, 0);
    rn = 1'b1;
    tick();

    // table-driven runs
    for (int i = 0; i < 6; i++)
      run_one(vecs[i].mode, vecs[i].pat, vecs[i].expv, vecs[i].resp, vecs[i].fail, 1'b0);

    // START held high: runs accepted at edges 0, 35, 70
    d_mode   = 1'b0;
    pattern  = 16'h0F0F;
    expect_v = 16'h0F0F;
    exp_q.push_back(16'd34);
    exp_q.push_back(16'd69);
    rise_q.push_back(16'd1);
    rise_q.push_back(16'd36);
    rise_q.push_back(16'd71);
    start = 1'b1;
    begin
      logic prev_busy;
      logic [15:0] w;
      logic seen3;
      prev_busy = busy;
      for (int c = 1; c <= 80; c++) begin
        tick();
        if (done) begin
          w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hFFFF;
          check("held_done_cycle", c, {16'd0, w});
          check("held_fail", fail, 0);
        end
        if (busy && !prev_busy) begin
          w = (rise_q.size() != 0) ? rise_q.pop_front() : 16'hFFFF;
          check("held_accept_cycle", c, {16'd0, w});
        end
        prev_busy = busy;
      end
      start = 1'b0;
      check("held_done_left", exp_q.size(), 0);
      seen3 = 1'b0;
      for (int c = 81; c <= 120; c++) begin
        tick();
        if (done) begin
          seen3 = 1'b1;
          check("held_run3_done", c, 104);
          check("held_run3_resp", resp, 16'h0F0F);
          break;
        end
      end
      if (!seen3) check("held_run3_timeout", 0, 1);
      check("held_accept_left", rise_q.size(), 0);
      tick();
    end

    // reset in the middle of UNLOAD (cycle 25)
    d_mode   = 1'b0;
    pattern  = 16'h1234;
    expect_v = 16'h0000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (24) tick();           // now in cycle 25
    check("pre_rst_busy", busy, 1);
    rn = 1'b0;
    tick();
    check("mid_rst_se_busy_done", {29'd0, se, busy, done}, 0);
    check("mid_rst_resp", resp, 0);
    check("mid_rst_state", dbg_state, 0);
    rn = 1'b1;
    begin
      int dones;
      dones = 0;
      for (int c = 0; c < 15; c++) begin
        tick();
        if (done) dones++;
      end
      check("no_done_after_rst", dones, 0);
    end
    run_one(1'b0, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0);

    // PATTERN/EXPECT changed after START must not affect the run
    run_one(1'b0, 16'h3C5A, 16'h3C5A, 16'h3C5A, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
